lbuf_dispatch_rr: RTL and testbench
===================================

# lbuf_dispatch_rr

Parametrised N-channel successor to the two-slot lbuf giver: arbitrates NUM_LBUF host-posted large buffers (lbufs) from hst_ctrl and hands them one at a time to the DMA write engine. Slots are served in round-robin order, with a strict-order mode or a skip-unready mode, and zero-length lbufs are auto-released. Sits between hst_ctrl (per-slot descriptor registers) and the RX DMA lbuf consumer.

## Interface
Parameters:
- NUM_LBUF, 4, number of lbuf slots (2..16)
- ADDR_W, 64, lbuf address width (32 or 64)
- LEN_W, 32, lbuf length width
- STRICT_ORDER, 1, 1 = wait on current slot until ready; 0 = skip to next ready slot
- IDX_W, $clog2(NUM_LBUF), slot index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- slot_addr  in  NUM_LBUF*ADDR_W  per-slot address, slot i at [i*ADDR_W +: ADDR_W]
- slot_len  in  NUM_LBUF*LEN_W  per-slot length
- slot_en  in  NUM_LBUF  slot holds a valid lbuf
- slot_dn  out  NUM_LBUF  one-cycle pulse: slot consumed, host may repost
- wt_lbuf  in  NUM_LBUF  slot i busy downstream, do not grant
- rd_lbuf  out  NUM_LBUF  one-hot, slot currently granted
- lbuf_addr  out  ADDR_W  granted address
- lbuf_len  out  LEN_W  granted length
- lbuf64b  out  1  |lbuf_addr[ADDR_W-1:32]; constant 0 when ADDR_W=32
- lbuf_idx  out  IDX_W  granted slot index
- lbuf_en  out  1  grant valid
- lbuf_dn  in  1  consumer finished the granted lbuf
- grant_cnt  out  32  total lbufs granted, wraps at 2^32

## Operation
- Slot i is ready when slot_en[i] && !wt_lbuf[i] && slot_len[i]!=0.
- Slot i is a zero-length slot when slot_en[i] && !wt_lbuf[i] && slot_len[i]==0.
- Round-robin pointer ptr (IDX_W bits) names the next slot to serve. It resets to 0.
- FSM states: INIT, SCAN, GRANT.
- INIT (entered on reset): all outputs 0. Go to SCAN next cycle.
- SCAN, STRICT_ORDER=1: only slot ptr is considered.
  - ptr ready: latch addr/len/lbuf64b/idx; set lbuf_en=1, rd_lbuf[ptr]=1; grant_cnt+1; go to GRANT.
  - ptr zero-length: pulse slot_dn[ptr], ptr+1, stay in SCAN.
  - Otherwise hold.
- SCAN, STRICT_ORDER=0: select the first slot that is ready or zero-length, searching ptr, ptr+1, ... with mod-NUM_LBUF wrap. A ready selection is granted as above. A zero-length selection is released as above, with ptr set to selection+1. If nothing qualifies, hold.
- GRANT: descriptor outputs stay frozen; changes to slot_* and wt_lbuf are ignored. On lbuf_dn: lbuf_en=0, rd_lbuf=0, slot_dn[idx] pulses, ptr = idx+1 mod NUM_LBUF, go to SCAN.
- ptr increment wraps NUM_LBUF-1 → 0, including for non-power-of-2 NUM_LBUF.

## Timing
- Reset values: lbuf_en, rd_lbuf, slot_dn, lbuf_addr, lbuf_len, lbuf64b, lbuf_idx and grant_cnt all 0.
- Grant latency: a slot ready in a SCAN cycle gives lbuf_en=1 on the next edge.
- Release: lbuf_dn sampled in GRANT → next edge lbuf_en=0 and slot_dn pulses. The earliest next lbuf_en is one cycle later, so there is at least one low cycle between grants.
- lbuf_dn outside GRANT is ignored.
- lbuf_dn held high is counted once per grant.
- slot_dn is exactly one cycle wide and never asserted for more than one slot in a cycle.
- All outputs are registered; there are no combinational input→output paths.
- Reset mid-GRANT abandons the grant: no slot_dn pulse, ptr returns to 0.
- A slot deasserting slot_en during its grant still gets its slot_dn pulse on lbuf_dn.

## Structure
- Shared package lbuf_pkg holds:
  - state encoding: INIT, SCAN, GRANT, one-hot 3 bits
  - LBUF_MAX_SLOTS=16
  - the default NUM_LBUF/ADDR_W/LEN_W values
- Sub-module rr_pick: combinational rotating priority encoder. Inputs: request vector and ptr. Outputs: hit and index. Used in STRICT_ORDER=0; in strict mode it reduces to a check of bit ptr.

## Test plan
- NUM_LBUF=4, strict; slots 0-3 enabled, len=0x1000, addresses 0x1_0000_0000+i; consumer ack 5 cycles after each lbuf_en → grants occur in order 0,1,2,3,0; lbuf64b=1; slot_dn pulses match lbuf_idx; grant_cnt=5.
- Strict mode, wt_lbuf[1]=1 for 20 cycles → lbuf_en stays low with ptr=1; slot 2 is not granted until wt_lbuf[1] drops.
- STRICT_ORDER=0, same stimulus → slot 2 is granted the cycle after slot 0's release; slot 1 is served when its wait clears.
- slot_len[2]=0, slot_en[2]=1 → slot_dn[2] pulses once with no lbuf_en and no rd_lbuf[2]; slot 3 is granted next; grant_cnt is not incremented for slot 2.
- NUM_LBUF=3, ADDR_W=32 → after slot 2, ptr wraps to 0 and lbuf64b stays 0; rst asserted in GRANT of slot 1 → all outputs 0, no slot_dn, the first grant after reset is slot 0.

Source files
------------

// File: rtl/lbuf_pkg.sv
// Shared definitions for the lbuf dispatcher: FSM state encoding and default sizing.
package lbuf_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'b001,
    ST_SCAN  = 3'b010,
    ST_GRANT = 3'b100
  } lbuf_state_t;

  localparam int LBUF_MAX_SLOTS   = 16;
  localparam int LBUF_DEF_NUM     = 4;
  localparam int LBUF_DEF_ADDR_W  = 64;
  localparam int LBUF_DEF_LEN_W   = 32;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit at or after ptr, wrapping mod N.
module rr_pick
  import lbuf_pkg::*;
#(
  parameter int N     = LBUF_DEF_NUM,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Walk from farthest to nearest so the slot closest to ptr wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap_add(ptr, i)]) begin
        hit = 1'b1;
        idx = wrap_add(ptr, i);
      end
    end
  end

endmodule

// File: rtl/lbuf_dispatch_rr.sv
// Round-robin dispatcher handing host-posted lbufs to the RX DMA one at a time.
//   state | meaning
//   INIT  | post-reset, all outputs cleared
//   SCAN  | looking for a ready or zero-length slot
//   GRANT | descriptor frozen on outputs, waiting for lbuf_dn
module lbuf_dispatch_rr
  import lbuf_pkg::*;
#(
  parameter int NUM_LBUF     = LBUF_DEF_NUM,
  parameter int ADDR_W       = LBUF_DEF_ADDR_W,
  parameter int LEN_W        = LBUF_DEF_LEN_W,
  parameter bit STRICT_ORDER = 1'b1,
  parameter int IDX_W        = $clog2(NUM_LBUF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LBUF*ADDR_W-1:0] slot_addr,
  input  logic [NUM_LBUF*LEN_W-1:0]  slot_len,
  input  logic [NUM_LBUF-1:0]        slot_en,
  output logic [NUM_LBUF-1:0]        slot_dn,
  input  logic [NUM_LBUF-1:0]        wt_lbuf,
  output logic [NUM_LBUF-1:0]        rd_lbuf,
  output logic [ADDR_W-1:0]          lbuf_addr,
  output logic [LEN_W-1:0]           lbuf_len,
  output logic                       lbuf64b,
  output logic [IDX_W-1:0]           lbuf_idx,
  output logic                       lbuf_en,
  input  logic                       lbuf_dn,
  output logic [31:0]                grant_cnt
);

  lbuf_state_t state, state_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [NUM_LBUF-1:0] slot_dn_nxt, rd_lbuf_nxt;
  logic [ADDR_W-1:0]   lbuf_addr_nxt;
  logic [LEN_W-1:0]    lbuf_len_nxt;
  logic                lbuf64b_nxt, lbuf_en_nxt;
  logic [IDX_W-1:0]    lbuf_idx_nxt;
  logic [31:0]         grant_cnt_nxt;

  logic [ADDR_W-1:0]   addr_a [NUM_LBUF];
  logic [LEN_W-1:0]    len_a  [NUM_LBUF];
  logic [NUM_LBUF-1:0] rdy, zlen, qual, req;
  logic                pick_hit;
  logic [IDX_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_64b;

  for (genvar i = 0; i < NUM_LBUF; i++) begin : g_slot
    assign addr_a[i] = slot_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]  = slot_len[i*LEN_W +: LEN_W];
    assign rdy[i]    = slot_en[i] & ~wt_lbuf[i] & (|len_a[i]);
    assign zlen[i]   = slot_en[i] & ~wt_lbuf[i] & ~(|len_a[i]);
  end

  // Strict mode masks the request down to the pointed-at slot only.
  assign qual = rdy | zlen;
  assign req  = STRICT_ORDER ? (qual & (NUM_LBUF'(1) << ptr)) : qual;

  rr_pick #(.N(NUM_LBUF), .IDX_W(IDX_W)) u_pick (
    .req (req),
    .ptr (ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign sel_addr = addr_a[pick_idx];

  if (ADDR_W > 32) begin : g_hi
    assign sel_64b = |sel_addr[ADDR_W-1:32];
  end else begin : g_lo
    assign sel_64b = 1'b0;
  end

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(NUM_LBUF - 1)) return '0;
    return p + IDX_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      ptr       <= '0;
      slot_dn   <= '0;
      rd_lbuf   <= '0;
      lbuf_addr <= '0;
      lbuf_len  <= '0;
      lbuf64b   <= 1'b0;
      lbuf_idx  <= '0;
      lbuf_en   <= 1'b0;
      grant_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      slot_dn   <= slot_dn_nxt;
      rd_lbuf   <= rd_lbuf_nxt;
      lbuf_addr <= lbuf_addr_nxt;
      lbuf_len  <= lbuf_len_nxt;
      lbuf64b   <= lbuf64b_nxt;
      lbuf_idx  <= lbuf_idx_nxt;
      lbuf_en   <= lbuf_en_nxt;
      grant_cnt <= grant_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    slot_dn_nxt   = '0;
    rd_lbuf_nxt   = rd_lbuf;
    lbuf_addr_nxt = lbuf_addr;
    lbuf_len_nxt  = lbuf_len;
    lbuf64b_nxt   = lbuf64b;
    lbuf_idx_nxt  = lbuf_idx;
    lbuf_en_nxt   = lbuf_en;
    grant_cnt_nxt = grant_cnt;
    case (state)
      ST_INIT: state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (pick_hit && rdy[pick_idx]) begin
          lbuf_addr_nxt = sel_addr;
          lbuf_len_nxt  = len_a[pick_idx];
          lbuf64b_nxt   = sel_64b;
          lbuf_idx_nxt  = pick_idx;
          lbuf_en_nxt   = 1'b1;
          rd_lbuf_nxt   = NUM_LBUF'(1) << pick_idx;
          grant_cnt_nxt = grant_cnt + 32'd1;
          state_nxt     = ST_GRANT;
        end else if (pick_hit) begin
          // Zero-length lbuf: hand it straight back without a grant.
          slot_dn_nxt = NUM_LBUF'(1) << pick_idx;
          ptr_nxt     = ptr_inc(pick_idx);
        end
      end
      ST_GRANT: begin
        if (lbuf_dn) begin
          lbuf_en_nxt = 1'b0;
          rd_lbuf_nxt = '0;
          slot_dn_nxt = NUM_LBUF'(1) << lbuf_idx;
          ptr_nxt     = ptr_inc(lbuf_idx);
          state_nxt   = ST_SCAN;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_lbuf_dispatch_rr.sv
// Directed bench for lbuf_dispatch_rr: strict, skip-unready and 3-slot/32-bit configurations.
module tb_lbuf_dispatch_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] dn_v = '0;
  int total = 0;
  int bad   = 0;

  // strict, 4 slots, 64-bit
  logic [255:0] s_addr = '0;
  logic [127:0] s_len  = '0;
  logic [3:0]   s_slot_en = '0, s_wt = '0, s_slot_dn, s_rd;
  logic [63:0]  s_laddr;
  logic [31:0]  s_llen, s_gcnt;
  logic         s_l64, s_lbuf_en;
  logic [1:0]   s_idx;

  // skip-unready, 4 slots, 64-bit
  logic [255:0] r_addr = '0;
  logic [127:0] r_len  = '0;
  logic [3:0]   r_slot_en = '0, r_wt = '0, r_slot_dn, r_rd;
  logic [63:0]  r_laddr;
  logic [31:0]  r_llen, r_gcnt;
  logic         r_l64, r_lbuf_en;
  logic [1:0]   r_idx;

  // strict, 3 slots, 32-bit
  logic [95:0]  w_addr = '0;
  logic [95:0]  w_len  = '0;
  logic [2:0]   w_slot_en = '0, w_wt = '0, w_slot_dn, w_rd;
  logic [31:0]  w_laddr;
  logic [31:0]  w_llen, w_gcnt;
  logic         w_l64, w_lbuf_en;
  logic [1:0]   w_idx;

  wire [2:0] en_v = {w_lbuf_en, r_lbuf_en, s_lbuf_en};

  lbuf_dispatch_rr #(.NUM_LBUF(4), .ADDR_W(64), .LEN_W(32), .STRICT_ORDER(1'b1)) u_s (
    .clk(clk), .rst(rst), .slot_addr(s_addr), .slot_len(s_len), .slot_en(s_slot_en),
    .slot_dn(s_slot_dn), .wt_lbuf(s_wt), .rd_lbuf(s_rd), .lbuf_addr(s_laddr),
    .lbuf_len(s_llen), .lbuf64b(s_l64), .lbuf_idx(s_idx), .lbuf_en(s_lbuf_en),
    .lbuf_dn(dn_v[0]), .grant_cnt(s_gcnt));

  lbuf_dispatch_rr #(.NUM_LBUF(4), .ADDR_W(64), .LEN_W(32), .STRICT_ORDER(1'b0)) u_r (
    .clk(clk), .rst(rst), .slot_addr(r_addr), .slot_len(r_len), .slot_en(r_slot_en),
    .slot_dn(r_slot_dn), .wt_lbuf(r_wt), .rd_lbuf(r_rd), .lbuf_addr(r_laddr),
    .lbuf_len(r_llen), .lbuf64b(r_l64), .lbuf_idx(r_idx), .lbuf_en(r_lbuf_en),
    .lbuf_dn(dn_v[1]), .grant_cnt(r_gcnt));

  lbuf_dispatch_rr #(.NUM_LBUF(3), .ADDR_W(32), .LEN_W(32), .STRICT_ORDER(1'b1)) u_w (
    .clk(clk), .rst(rst), .slot_addr(w_addr), .slot_len(w_len), .slot_en(w_slot_en),
    .slot_dn(w_slot_dn), .wt_lbuf(w_wt), .rd_lbuf(w_rd), .lbuf_addr(w_laddr),
    .lbuf_len(w_llen), .lbuf64b(w_l64), .lbuf_idx(w_idx), .lbuf_en(w_lbuf_en),
    .lbuf_dn(dn_v[2]), .grant_cnt(w_gcnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    dn_v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int k, input string tag);
    int n = 0;
    while (en_v[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(en_v[k]), 64'd1);
  endtask

  // Returns on the negedge where the release is visible on the outputs.
  task automatic ack(input int k, input int d);
    repeat (d) @(negedge clk);
    dn_v[k] = 1'b1;
    @(negedge clk);
    dn_v[k] = 1'b0;
  endtask

  initial begin
    int e;
    logic seen;

    for (int i = 0; i < 4; i++) begin
      s_addr[i*64 +: 64] = 64'h1_0000_0000 + 64'(i);
      s_len[i*32 +: 32]  = 32'h1000;
      r_addr[i*64 +: 64] = 64'h1_0000_0000 + 64'(i);
      r_len[i*32 +: 32]  = 32'h1000;
    end
    for (int i = 0; i < 3; i++) begin
      w_addr[i*32 +: 32] = 32'h100 + 32'(i);
      w_len[i*32 +: 32]  = 32'h40;
    end

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_en",   64'(s_lbuf_en), 64'd0);
    chk("rst_rd",   64'(s_rd),      64'd0);
    chk("rst_sdn",  64'(s_slot_dn), 64'd0);
    chk("rst_addr", s_laddr,        64'd0);
    chk("rst_len",  64'(s_llen),    64'd0);
    chk("rst_64b",  64'(s_l64),     64'd0);
    chk("rst_idx",  64'(s_idx),     64'd0);
    chk("rst_gcnt", 64'(s_gcnt),    64'd0);

    // strict round robin 0,1,2,3,0 with ack 5 cycles after grant
    s_slot_en = 4'hF;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      e = g % 4;
      wait_grant(0, "t1_grant_wait");
      chk("t1_idx",  64'(s_idx),  64'(e));
      chk("t1_rd",   64'(s_rd),   64'd1 << e);
      chk("t1_addr", s_laddr,     64'h1_0000_0000 + 64'(e));
      chk("t1_len",  64'(s_llen), 64'h1000);
      chk("t1_64b",  64'(s_l64),  64'd1);
      ack(0, 5);
      chk("t1_rel_en",  64'(s_lbuf_en), 64'd0);
      chk("t1_rel_sdn", 64'(s_slot_dn), 64'd1 << e);
      chk("t1_gcnt",    64'(s_gcnt),    64'(g + 1));
      @(negedge clk);
      chk("t1_sdn_width", 64'(s_slot_dn), 64'd0);
      chk("t1_next_en",   64'(s_lbuf_en), 64'd1);
    end

    // strict: slot 1 waiting blocks slot 2
    s_wt = 4'b0010;
    do_reset();
    wait_grant(0, "t2_grant_wait");
    chk("t2_idx0", 64'(s_idx), 64'd0);
    ack(0, 1);
    chk("t2_rel_sdn", 64'(s_slot_dn), 64'b0001);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | s_lbuf_en | s_rd[2];
    end
    chk("t2_strict_hold", 64'(seen), 64'd0);
    s_wt = 4'b0000;
    wait_grant(0, "t2_grant_wait1");
    chk("t2_idx1", 64'(s_idx), 64'd1);
    ack(0, 1);
    wait_grant(0, "t2_grant_wait2");
    chk("t2_idx2", 64'(s_idx), 64'd2);

    // skip-unready: slot 2 follows slot 0, slot 1 served once its wait clears
    r_slot_en = 4'hF;
    r_wt      = 4'b0010;
    do_reset();
    wait_grant(1, "t3_grant_wait");
    chk("t3_idx0", 64'(r_idx), 64'd0);
    ack(1, 5);
    chk("t3_rel_en",  64'(r_lbuf_en), 64'd0);
    chk("t3_rel_sdn", 64'(r_slot_dn), 64'b0001);
    @(negedge clk);
    chk("t3_skip_en",  64'(r_lbuf_en), 64'd1);
    chk("t3_skip_idx", 64'(r_idx),     64'd2);
    r_slot_en = 4'b0010;
    r_wt      = 4'b0000;
    @(negedge clk);
    chk("t3_frozen_addr", r_laddr,     64'h1_0000_0002);
    chk("t3_frozen_rd",   64'(r_rd),   64'b0100);
    ack(1, 2);
    chk("t3_dropped_sdn", 64'(r_slot_dn), 64'b0100);
    chk("t3_rel2_en",     64'(r_lbuf_en), 64'd0);
    @(negedge clk);
    chk("t3_slot1_en",  64'(r_lbuf_en), 64'd1);
    chk("t3_slot1_idx", 64'(r_idx),     64'd1);

    // zero-length slot 2 released without a grant
    s_len[2*32 +: 32] = 32'h0;
    do_reset();
    wait_grant(0, "t4_grant_wait0");
    chk("t4_idx0", 64'(s_idx), 64'd0);
    ack(0, 1);
    wait_grant(0, "t4_grant_wait1");
    chk("t4_idx1", 64'(s_idx), 64'd1);
    ack(0, 1);
    chk("t4_rel1_sdn", 64'(s_slot_dn), 64'b0010);
    @(negedge clk);
    chk("t4_zero_sdn", 64'(s_slot_dn), 64'b0100);
    chk("t4_zero_en",  64'(s_lbuf_en), 64'd0);
    chk("t4_zero_rd",  64'(s_rd),      64'd0);
    @(negedge clk);
    chk("t4_next_en",  64'(s_lbuf_en), 64'd1);
    chk("t4_next_idx", 64'(s_idx),     64'd3);
    chk("t4_sdn_clr",  64'(s_slot_dn), 64'd0);
    chk("t4_gcnt",     64'(s_gcnt),    64'd3);

    // 3 slots, 32-bit: wrap after slot 2, then reset mid-grant
    w_slot_en = 3'b111;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      e = g % 3;
      wait_grant(2, "t5_grant_wait");
      chk("t5_idx",  64'(w_idx),   64'(e));
      chk("t5_addr", 64'(w_laddr), 64'h100 + 64'(e));
      chk("t5_64b",  64'(w_l64),   64'd0);
      ack(2, 1);
      chk("t5_rel_sdn", 64'(w_slot_dn), 64'd1 << e);
    end
    wait_grant(2, "t5_grant_wait1");
    chk("t5_idx1", 64'(w_idx), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_en",   64'(w_lbuf_en), 64'd0);
    chk("t5_rst_rd",   64'(w_rd),      64'd0);
    chk("t5_rst_sdn",  64'(w_slot_dn), 64'd0);
    chk("t5_rst_idx",  64'(w_idx),     64'd0);
    chk("t5_rst_addr", 64'(w_laddr),   64'd0);
    chk("t5_rst_gcnt", 64'(w_gcnt),    64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | (|w_slot_dn);
    end
    chk("t5_no_sdn",      64'(seen),      64'd0);
    chk("t5_after_en",    64'(w_lbuf_en), 64'd1);
    chk("t5_after_idx",   64'(w_idx),     64'd0);
    chk("t5_after_gcnt",  64'(w_gcnt),    64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
